// File: rtl/st_tcdm_bank_nx32.sv
// rtl/st_tcdm_bank_nx32.sv - single-port NUM_WORDS x 32 TCDM bank with bit-masked writes and registered read data
module st_tcdm_bank_nx32 #(
  parameter int NUM_WORDS = 1024,
  parameter int RM_SIZE = 3,
  parameter int WM_SIZE = 3,
  localparam int AW = $clog2(NUM_WORDS)
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic               INITN,
  input  logic               STDBY,
  input  logic               CSN,
  input  logic               WEN,
  input  logic [31:0]        WMN,
  input  logic [AW-1:0]      A,
  input  logic [31:0]        D,
  output logic [31:0]        Q,
  input  logic               LS,
  input  logic               HS,
  input  logic [RM_SIZE-1:0] RM,
  input  logic [WM_SIZE-1:0] WM,
  input  logic               TM
);

  if (NUM_WORDS != 512 && NUM_WORDS != 1024 && NUM_WORDS != 2048) begin : g_bad_num_words
    $error("st_tcdm_bank_nx32: NUM_WORDS must be 512, 1024 or 2048");
  end

  logic [31:0] mem [NUM_WORDS];
  logic        access;
  logic        wr_en;
  logic        rd_en;

  // RSTN is named like an active-low pin but is active-high.
  assign access = INITN & ~STDBY & ~CSN;
  assign wr_en  = ~RSTN & access & ~WEN;
  assign rd_en  = access & WEN;

  // Storage has no reset so contents survive RSTN and INITN.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[A] <= (mem[A] & WMN) | (D & ~WMN);
    end
  end

  always_ff @(posedge CLK or posedge RSTN) begin
    if (RSTN) begin
      Q <= '0;
    end else if (!INITN) begin
      Q <= '0;
    end else if (rd_en) begin
      Q <= mem[A];
    end
  end

  // Margin and speed hints are accepted for pin compatibility only.
  logic unused_perf;
  assign unused_perf = ^{LS, HS, RM, WM, TM};

`ifndef SYNTHESIS
  always @(posedge CLK) begin
    if ($isunknown({CSN, WEN, RSTN})) begin
      $warning("st_tcdm_bank_nx32: X/Z on CSN, WEN or RSTN");
    end
  end
`endif

endmodule

// File: tb/tb_st_tcdm_bank_nx32.sv
// tb/tb_st_tcdm_bank_nx32.sv - self-checking bench for st_tcdm_bank_nx32 against a bit-level reference model
module tb_st_tcdm_bank_nx32;

  logic        clk;
  logic        rstn, initn, stdby, wen;
  logic        csn, csn_512, csn_2048;
  logic [31:0] wmn, d;
  logic [10:0] a;
  logic        ls, hs, tm;
  logic [2:0]  rm, wm;
  logic [31:0] q_main, q_512, q_2048;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] ref_mem [0:1023];
  logic [31:0] exp_q;

  st_tcdm_bank_nx32 #(.NUM_WORDS(1024)) dut (
    .CLK(clk), .RSTN(rstn), .INITN(initn), .STDBY(stdby), .CSN(csn), .WEN(wen),
    .WMN(wmn), .A(a[9:0]), .D(d), .Q(q_main),
    .LS(ls), .HS(hs), .RM(rm), .WM(wm), .TM(tm)
  );

  st_tcdm_bank_nx32 #(.NUM_WORDS(512)) dut_512 (
    .CLK(clk), .RSTN(rstn), .INITN(initn), .STDBY(stdby), .CSN(csn_512), .WEN(wen),
    .WMN(wmn), .A(a[8:0]), .D(d), .Q(q_512),
    .LS(ls), .HS(hs), .RM(rm), .WM(wm), .TM(tm)
  );

  st_tcdm_bank_nx32 #(.NUM_WORDS(2048)) dut_2048 (
    .CLK(clk), .RSTN(rstn), .INITN(initn), .STDBY(stdby), .CSN(csn_2048), .WEN(wen),
    .WMN(wmn), .A(a[10:0]), .D(d), .Q(q_2048),
    .LS(ls), .HS(hs), .RM(rm), .WM(wm), .TM(tm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour of the 1024-word bank for one rising edge.
  task automatic model_step();
    if (rstn) begin
      exp_q = 32'h0;
    end else if (!initn) begin
      exp_q = 32'h0;
    end else if (!stdby && !csn) begin
      if (!wen) begin
        for (int k = 0; k < 32; k++) begin
          if (wmn[k] == 1'b0) ref_mem[a[9:0]][k] = d[k];
        end
      end else begin
        exp_q = ref_mem[a[9:0]];
      end
    end
  endtask

  // sel: 0 = 1024-word bank, 1 = 512-word bank, 2 = 2048-word bank, other = idle.
  task automatic op(input int sel, input logic wen_i, input logic [10:0] a_i,
                    input logic [31:0] d_i, input logic [31:0] wmn_i);
    csn      = (sel != 0);
    csn_512  = (sel != 1);
    csn_2048 = (sel != 2);
    wen = wen_i; a = a_i; d = d_i; wmn = wmn_i;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_perf(input logic ls_i, hs_i, tm_i, input logic [2:0] rm_i, wm_i);
    ls = ls_i; hs = hs_i; tm = tm_i; rm = rm_i; wm = wm_i;
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    op(-1, 1'b1, 11'd0, 32'h0, 32'h0);
    op(0, 1'b1, 11'd1, 32'h0, 32'h0);
    n_checks++; if (q_main !== 32'h0) begin n_fail++; $display("FAIL reset_q_1024: Q=%h expected %h", q_main, 32'h0); end
    n_checks++; if (q_512 !== 32'h0) begin n_fail++; $display("FAIL reset_q_512: Q=%h expected %h", q_512, 32'h0); end
    n_checks++; if (q_2048 !== 32'h0) begin n_fail++; $display("FAIL reset_q_2048: Q=%h expected %h", q_2048, 32'h0); end
    rstn = 1'b0;
  endtask

  task automatic test_full_write_read(input string tag);
    op(0, 1'b0, 11'd5, 32'hDEADBEEF, 32'h0);
    n_checks++; if (q_main !== exp_q) begin n_fail++; $display("FAIL %s_write_holds_q: Q=%h expected %h", tag, q_main, exp_q); end
    op(0, 1'b1, 11'd5, 32'h0, 32'hFFFFFFFF);
    n_checks++; if (q_main !== 32'hDEADBEEF) begin n_fail++; $display("FAIL %s_read: Q=%h expected %h", tag, q_main, 32'hDEADBEEF); end
    op(-1, 1'b1, 11'd0, 32'h0, 32'h0);
    n_checks++; if (q_main !== 32'hDEADBEEF) begin n_fail++; $display("FAIL %s_idle_hold: Q=%h expected %h", tag, q_main, 32'hDEADBEEF); end
  endtask

  task automatic test_masked_write();
    op(0, 1'b0, 11'd7, 32'hFFFFFFFF, 32'h0);
    op(0, 1'b0, 11'd7, 32'h00000000, 32'hFFFF00FF);
    op(0, 1'b1, 11'd7, 32'h13572468, 32'h0);
    n_checks++; if (q_main !== 32'hFFFF00FF) begin n_fail++; $display("FAIL masked_write: Q=%h expected %h", q_main, 32'hFFFF00FF); end
    op(0, 1'b0, 11'd7, 32'h0, 32'hFFFFFFFF);
    op(0, 1'b1, 11'd7, 32'h0, 32'h0);
    n_checks++; if (q_main !== 32'hFFFF00FF) begin n_fail++; $display("FAIL all_ones_mask: Q=%h expected %h", q_main, 32'hFFFF00FF); end
  endtask

  task automatic test_reset_retention();
    op(0, 1'b0, 11'd9, 32'h12345678, 32'h0);
    op(0, 1'b1, 11'd9, 32'h0, 32'h0);
    n_checks++; if (q_main !== 32'h12345678) begin n_fail++; $display("FAIL retention_pre: Q=%h expected %h", q_main, 32'h12345678); end
    #3;
    rstn = 1'b1;
    exp_q = 32'h0;
    #1;
    n_checks++; if (q_main !== 32'h0) begin n_fail++; $display("FAIL async_reset: Q=%h expected %h", q_main, 32'h0); end
    op(0, 1'b0, 11'd9, 32'h0, 32'h0);
    n_checks++; if (q_main !== 32'h0) begin n_fail++; $display("FAIL reset_hold: Q=%h expected %h", q_main, 32'h0); end
    rstn = 1'b0;
    op(0, 1'b1, 11'd9, 32'h0, 32'h0);
    n_checks++; if (q_main !== 32'h12345678) begin n_fail++; $display("FAIL retention_post: Q=%h expected %h", q_main, 32'h12345678); end
  endtask

  task automatic test_gating();
    op(0, 1'b0, 11'd3, 32'h33333333, 32'h0);
    op(0, 1'b1, 11'd9, 32'h0, 32'h0);
    stdby = 1'b1;
    op(0, 1'b0, 11'd3, 32'hAAAAAAAA, 32'h0);
    n_checks++; if (q_main !== 32'h12345678) begin n_fail++; $display("FAIL stdby_write_q: Q=%h expected %h", q_main, 32'h12345678); end
    op(0, 1'b1, 11'd3, 32'h0, 32'h0);
    n_checks++; if (q_main !== 32'h12345678) begin n_fail++; $display("FAIL stdby_read_q: Q=%h expected %h", q_main, 32'h12345678); end
    stdby = 1'b0;
    op(0, 1'b1, 11'd3, 32'h0, 32'h0);
    n_checks++; if (q_main !== 32'h33333333) begin n_fail++; $display("FAIL stdby_no_write: Q=%h expected %h", q_main, 32'h33333333); end
    initn = 1'b0;
    op(-1, 1'b1, 11'd0, 32'h0, 32'h0);
    n_checks++; if (q_main !== 32'h0) begin n_fail++; $display("FAIL initn_clear: Q=%h expected %h", q_main, 32'h0); end
    op(0, 1'b1, 11'd9, 32'h0, 32'h0);
    n_checks++; if (q_main !== 32'h0) begin n_fail++; $display("FAIL initn_read: Q=%h expected %h", q_main, 32'h0); end
    op(0, 1'b0, 11'd9, 32'h0, 32'h0);
    initn = 1'b1;
    op(0, 1'b1, 11'd9, 32'h0, 32'h0);
    n_checks++; if (q_main !== 32'h12345678) begin n_fail++; $display("FAIL initn_no_write: Q=%h expected %h", q_main, 32'h12345678); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [4];
    for (int i = 0; i < 4; i++) begin
      vals[i] = $urandom;
      op(0, 1'b0, 11'(20 + i), vals[i], 32'h0);
    end
    for (int i = 0; i < 4; i++) begin
      op(0, 1'b1, 11'(20 + i), 32'h0, 32'h0);
      n_checks++; if (q_main !== vals[i]) begin n_fail++; $display("FAIL b2b_read_%0d: Q=%h expected %h", i, q_main, vals[i]); end
    end
  endtask

  task automatic test_depth();
    int          depth [3];
    logic [31:0] v0, v1, got;
    depth[0] = 1024; depth[1] = 512; depth[2] = 2048;
    for (int s = 0; s < 3; s++) begin
      v0 = 32'hA0000000 | 32'(depth[s]);
      v1 = 32'h5F000000 | 32'(depth[s] - 1);
      op(s, 1'b0, 11'd0, v0, 32'h0);
      op(s, 1'b0, 11'(depth[s] - 1), v1, 32'h0);
      op(s, 1'b1, 11'd0, 32'h0, 32'h0);
      got = (s == 0) ? q_main : (s == 1) ? q_512 : q_2048;
      n_checks++; if (got !== v0) begin n_fail++; $display("FAIL depth%0d_addr0: Q=%h expected %h", depth[s], got, v0); end
      op(s, 1'b1, 11'(depth[s] - 1), 32'h0, 32'h0);
      got = (s == 0) ? q_main : (s == 1) ? q_512 : q_2048;
      n_checks++; if (got !== v1) begin n_fail++; $display("FAIL depth%0d_addr_last: Q=%h expected %h", depth[s], got, v1); end
    end
  endtask

  task automatic test_random();
    logic [31:0] m;
    int          errs = 0;
    for (int i = 0; i < 16; i++) op(0, 1'b0, 11'(i), $urandom, 32'h0);
    for (int n = 0; n < 400; n++) begin
      set_perf(1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), 3'($urandom));
      stdby = ($urandom_range(0, 7) == 0);
      initn = ($urandom_range(0, 15) != 0);
      case ($urandom_range(0, 3))
        0: m = 32'h0;
        1: m = 32'hFFFFFFFF;
        default: m = $urandom;
      endcase
      op(($urandom_range(0, 3) == 0) ? -1 : 0, 1'($urandom), 11'($urandom_range(0, 15)), $urandom, m);
      n_checks++;
      if (q_main !== exp_q) begin
        n_fail++;
        if (errs < 10) $display("FAIL random_%0d: Q=%h expected %h", n, q_main, exp_q);
        errs++;
      end
    end
    stdby = 1'b0; initn = 1'b1;
    set_perf(1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
  endtask

  initial begin
    rstn = 1'b1; initn = 1'b1; stdby = 1'b0; wen = 1'b1;
    csn = 1'b1; csn_512 = 1'b1; csn_2048 = 1'b1;
    wmn = 32'hFFFFFFFF; d = 32'h0; a = 11'd0;
    exp_q = 32'h0;
    set_perf(1'b0, 1'b0, 1'b0, 3'd0, 3'd0);

    test_reset();
    test_full_write_read("full");
    set_perf(1'b1, 1'b1, 1'b1, 3'd7, 3'd0);
    test_full_write_read("perf");
    set_perf(1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
    test_masked_write();
    test_reset_retention();
    test_gating();
    test_back_to_back();
    test_depth();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
